pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage integer pipeline. Drives the per-stage

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared hazard-control types: sequencer states and the stage-flag bit positions
// used by decode, the stage latches and the hazard sequencer.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MC_WAIT  = 2'd2
  } hz_state_t;

  localparam int REG_W         = 5;
  localparam int FLAG_W        = 16;
  localparam int FLAG_MEM_READ = 0;
  localparam int FLAG_MC       = 1;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the ID instruction needs a register that the load in EX
// has not produced yet. x0 never creates a dependency.
module hazard_detect import hazard_pkg::*; (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: latch controls from load-use,
// taken-branch, data-memory wait and multi-cycle EX events, plus perf counters.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   RUN      | normal flow; branch flush and load-use bubble decided here
//   MEM_WAIT | data access outstanding, everything up to EX/MEM frozen
//   MC_WAIT  | multi-cycle op owns EX, front end held, bubbles into MEM
module pipeline_hazard_ctrl import hazard_pkg::*; #(
  parameter int MC_LATENCY = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_mc_start,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_ena,
  output logic             idex_hold,
  output logic             idex_ena,
  output logic             exmem_hold,
  output logic             exmem_ena,
  output logic             memwb_ena,
  output logic             mc_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int              MC_W    = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
  localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_LATENCY - 2);

  hz_state_t       state;
  logic [MC_W-1:0] mc_cnt;
  logic            mc_pend;
  logic            load_use;
  logic            mem_stall;
  logic            mc_active;
  logic            flush_evt;

  hazard_detect u_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // mc_pend remembers that a memory wait interrupted a multi-cycle op.
  always_comb begin
    mem_stall  = mem_req && !mem_ready;
    mc_active  = (state == MC_WAIT) || ((state == MEM_WAIT) && mc_pend);
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    idex_hold  = 1'b0;
    exmem_hold = 1'b0;
    ifid_ena   = 1'b1;
    idex_ena   = 1'b1;
    exmem_ena  = 1'b1;
    memwb_ena  = 1'b1;
    mc_done    = 1'b0;
    flush_evt  = 1'b0;
    if (!rst_n) begin
      ifid_ena  = 1'b0;
      idex_ena  = 1'b0;
      exmem_ena = 1'b0;
      memwb_ena = 1'b0;
    end else if (mem_stall) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
      memwb_ena  = 1'b0;
    end else if (mc_active || ex_mc_start) begin
      if (mc_active && (mc_cnt == '0)) begin
        mc_done = 1'b1;
      end else begin
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
        idex_hold = 1'b1;
        exmem_ena = 1'b0;
      end
    end else if (ex_branch_taken) begin
      ifid_ena  = 1'b0;
      idex_ena  = 1'b0;
      flush_evt = 1'b1;
    end else if (load_use) begin
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
      idex_ena  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      mc_cnt       <= '0;
      mc_pend      <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (mem_stall) begin
        state   <= MEM_WAIT;
        mc_pend <= mc_active;
      end else if (mc_active) begin
        mc_pend <= 1'b0;
        if (mc_cnt == '0) begin
          state <= RUN;
        end else begin
          state  <= MC_WAIT;
          mc_cnt <= mc_cnt - MC_W'(1);
        end
      end else if (ex_mc_start) begin
        state   <= MC_WAIT;
        mc_cnt  <= MC_LOAD;
        mc_pend <= 1'b0;
      end else begin
        state   <= RUN;
        mc_pend <= 1'b0;
      end
      if (pc_hold && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_evt && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a cycle-level behavioural model checks every
// cycle, and literal expectations pin latencies, stall counts and saturation.
module tb_pipeline_hazard_ctrl;

  localparam int MC_LAT  = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_mc_start, ex_branch_taken;
  logic       mem_req, mem_ready;
  logic       pc_hold, ifid_hold, ifid_ena, idex_hold, idex_ena;
  logic       exmem_hold, exmem_ena, memwb_ena, mc_done;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.MC_LATENCY(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mc_start(ex_mc_start),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_ena(ifid_ena),
    .idex_hold(idex_hold), .idex_ena(idex_ena), .exmem_hold(exmem_hold),
    .exmem_ena(exmem_ena), .memwb_ena(memwb_ena), .mc_done(mc_done),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: busy = EX cycles the multi-cycle op still needs (0 = none in flight).
  int busy = 0;
  int m_stall = 0;
  int m_flush = 0;

  always @(negedge clk) begin : model
    bit e_pch, e_ifh, e_idh, e_exh, e_ife, e_ide, e_exe, e_wbe, e_done;
    bit mst, lu;
    int rem;
    chk("model_stall_cycles", 32'(stall_cycles), m_stall);
    chk("model_flush_count", 32'(flush_count), m_flush);
    {e_pch, e_ifh, e_idh, e_exh} = 4'b0000;
    {e_ife, e_ide, e_exe, e_wbe} = 4'b1111;
    e_done = 1'b0;
    if (!rst_n) begin
      {e_ife, e_ide, e_exe, e_wbe} = 4'b0000;
      busy = 0; m_stall = 0; m_flush = 0;
    end else begin
      mst = mem_req && !mem_ready;
      lu  = ex_mem_read && (ex_rd != 0) &&
            ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      if (mst) begin
        {e_pch, e_ifh, e_idh, e_exh} = 4'b1111;
        e_wbe = 1'b0;
      end else if (busy > 0 || ex_mc_start) begin
        rem = (busy > 0) ? busy : MC_LAT;
        if (rem == 1) e_done = 1'b1;
        else begin
          {e_pch, e_ifh, e_idh} = 3'b111;
          e_exe = 1'b0;
        end
        busy = rem - 1;
      end else if (ex_branch_taken) begin
        e_ife = 1'b0; e_ide = 1'b0;
        if (m_flush < CNT_MAX) m_flush++;
      end else if (lu) begin
        e_pch = 1'b1; e_ifh = 1'b1; e_ide = 1'b0;
      end
      if (e_pch && m_stall < CNT_MAX) m_stall++;
    end
    chk("model_pc_hold", 32'(pc_hold), 32'(e_pch));
    chk("model_ifid_hold", 32'(ifid_hold), 32'(e_ifh));
    chk("model_idex_hold", 32'(idex_hold), 32'(e_idh));
    chk("model_exmem_hold", 32'(exmem_hold), 32'(e_exh));
    chk("model_memwb_ena", 32'(memwb_ena), 32'(e_wbe));
    chk("model_mc_done", 32'(mc_done), 32'(e_done));
    if (!e_ifh) chk("model_ifid_ena", 32'(ifid_ena), 32'(e_ife));
    if (!e_idh) chk("model_idex_ena", 32'(idex_ena), 32'(e_ide));
    if (!e_exh) chk("model_exmem_ena", 32'(exmem_ena), 32'(e_exe));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_mc_start = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic reset_dut();
    tick(); clr(); rst_n = 0;
    tick(); rst_n = 1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  int holds, done_at, wb_bub, done_seen;

  initial begin
    rst_n = 0; clr();
    // reset: everything bubbles, nothing held
    @(negedge clk);
    chk("rst_enas", {ifid_ena, idex_ena, exmem_ena, memwb_ena}, 0);
    chk("rst_holds", {pc_hold, ifid_hold, idex_hold, exmem_hold}, 0);
    chk("rst_counters", {stall_cycles, flush_count}, 0);
    tick(); @(negedge clk);
    chk("rst_enas2", {ifid_ena, idex_ena, exmem_ena, memwb_ena}, 0);
    tick(); rst_n = 1; @(negedge clk);
    chk("run_enas", {ifid_ena, idex_ena, exmem_ena, memwb_ena}, 4'hf);
    chk("run_holds", {pc_hold, ifid_hold, idex_hold, exmem_hold}, 0);

    // load-use on rs2
    tick(); ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
    @(negedge clk);
    chk("lu_pc_hold", pc_hold, 1);
    chk("lu_ifid_hold", ifid_hold, 1);
    chk("lu_idex_ena", idex_ena, 0);
    tick(); clr(); @(negedge clk);
    chk("lu_cleared", pc_hold, 0);
    chk("lu_stall_cnt", stall_cycles, 1);
    tick(); ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_uses_rs2 = 1;
    @(negedge clk);
    chk("lu_x0", pc_hold, 0);
    tick(); ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 0; id_rs2 = 3; id_uses_rs2 = 1;
    @(negedge clk);
    chk("lu_rs1_unused", pc_hold, 0);
    tick(); id_uses_rs1 = 1; @(negedge clk);
    chk("lu_rs1", pc_hold, 1);
    tick(); clr(); @(negedge clk);
    chk("lu_stall_cnt2", stall_cycles, 2);

    // branch wins over load-use in the same cycle
    tick(); ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_uses_rs1 = 1; ex_branch_taken = 1;
    @(negedge clk);
    chk("br_ifid_ena", ifid_ena, 0);
    chk("br_idex_ena", idex_ena, 0);
    chk("br_pc_hold", pc_hold, 0);
    tick(); clr(); @(negedge clk);
    chk("br_flush_cnt", flush_count, 1);
    chk("br_stall_cnt", stall_cycles, 2);

    // multi-cycle op: 3 held cycles, done on the 4th; branches while held are ignored
    reset_dut(); ex_mc_start = 1;
    holds = 0; done_at = -1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        tick(); ex_mc_start = 0; ex_branch_taken = (i == 1 || i == 2);
      end
      @(negedge clk);
      if (pc_hold === 1'b1) holds++;
      if (mc_done === 1'b1 && done_at < 0) done_at = i;
    end
    tick(); clr(); @(negedge clk);
    chk("mc_hold_cycles", holds, 3);
    chk("mc_done_cycle", done_at, 3);
    chk("mc_stall_cnt", stall_cycles, 3);
    chk("mc_flush_ignored", flush_count, 0);

    // memory wait for 3 cycles inside the multi-cycle op freezes its count
    reset_dut();
    holds = 0; done_at = -1; wb_bub = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      ex_mc_start = (i == 0);
      mem_req = (i >= 1 && i <= 4);
      mem_ready = (i == 4);
      @(negedge clk);
      if (pc_hold === 1'b1) holds++;
      if (mc_done === 1'b1 && done_at < 0) done_at = i;
      if (memwb_ena === 1'b0) wb_bub++;
      if (i == 2) chk("mw_exmem_hold", exmem_hold, 1);
    end
    tick(); clr(); @(negedge clk);
    chk("mw_done_cycle", done_at, 6);
    chk("mw_wb_bubbles", wb_bub, 3);
    chk("mw_hold_cycles", holds, 6);
    chk("mw_stall_cnt", stall_cycles, 6);

    // reset in the middle of the multi-cycle op aborts it
    reset_dut(); ex_mc_start = 1;
    tick(); ex_mc_start = 0;
    tick(); rst_n = 0; @(negedge clk);
    chk("abort_rst_ena", ifid_ena, 0);
    tick(); rst_n = 1;
    done_seen = 0; holds = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      if (mc_done === 1'b1) done_seen++;
      if (pc_hold === 1'b1) holds++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_no_hold", holds, 0);

    // saturation of both counters
    tick(); mem_req = 1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) tick();
      @(negedge clk);
    end
    tick(); clr(); @(negedge clk);
    chk("sat_stall", stall_cycles, CNT_MAX);
    tick(); ex_branch_taken = 1;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) tick();
      @(negedge clk);
    end
    tick(); clr(); @(negedge clk);
    chk("sat_flush", flush_count, CNT_MAX);
    chk("sat_stall_kept", stall_cycles, CNT_MAX);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
